// File: rtl/immgen_pipe.sv
// Purpose: decode-stage immediate generator (I/S/B/U/J), sign-extended to XLEN, with format code and illegal flag.
// Latency: one cycle from accept to out_valid when empty; throughput one entry per cycle.
// Backpressure: SKID=1 holds up to two entries behind a registered in_ready; SKID=0 holds one with in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   flush                        synchronous drop of every held entry (beats accept/retire)
//   in_valid/in_ready            upstream handshake; in_ins instruction, in_tag sideband (PC)
//   out_valid/out_ready          downstream handshake
//   out_imm/out_fmt/out_illegal  decoded immediate, format (0 NONE,1 I,2 S,3 B,4 U,5 J), bad opcode
//   out_ins/out_tag              instruction and tag travelling with the result
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_ins,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [31:0]      ins;
    logic [TAG_W-1:0] tag;
  } ent_t;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  // Every format fits a 32-bit signed value whose sign sits at bit 31, so the
  // decode works at 32 bits and a signed width cast extends it to XLEN.
  logic signed [31:0] imm32;
  logic [2:0]         fmt_d;
  logic               ill_d;
  ent_t               in_ent;
  ent_t               main_q;
  logic               acc;
  logic               ret;

  always_comb begin
    imm32 = '0;
    fmt_d = FMT_NONE;
    ill_d = 1'b0;
    if (in_ins[1:0] != 2'b11) begin
      ill_d = 1'b1;
    end else begin
      case (in_ins[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
          fmt_d = FMT_I;
          imm32 = {{20{in_ins[31]}}, in_ins[31:20]};
        end
        7'b0100011: begin
          fmt_d = FMT_S;
          imm32 = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
        end
        7'b1100011: begin
          fmt_d = FMT_B;
          imm32 = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          fmt_d = FMT_U;
          imm32 = {in_ins[31:12], 12'b0};
        end
        7'b1101111: begin
          fmt_d = FMT_J;
          imm32 = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
        end
        7'b0110011, 7'b0001111: begin
          fmt_d = FMT_NONE;
        end
        default: begin
          ill_d = 1'b1;
        end
      endcase
    end
  end

  assign in_ent.imm     = XLEN'(imm32);
  assign in_ent.fmt     = fmt_d;
  assign in_ent.illegal = ill_d;
  assign in_ent.ins     = in_ins;
  assign in_ent.tag     = in_tag;

  assign acc = in_valid && in_ready;
  assign ret = out_valid && out_ready;

  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_ins     = main_q.ins;
  assign out_tag     = main_q.tag;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

      state_t state_q, state_d;
      ent_t   skid_q;
      logic   rdy_q;
      logic   load_main, load_skid, pop_skid;

      always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        if (flush) begin
          state_d = EMPTY;
        end else begin
          case (state_q)
            EMPTY: begin
              if (acc) begin
                state_d   = ONE;
                load_main = 1'b1;
              end
            end
            ONE: begin
              if (acc && ret) begin
                load_main = 1'b1;
              end else if (acc) begin
                state_d   = TWO;
                load_skid = 1'b1;
              end else if (ret) begin
                state_d = EMPTY;
              end
            end
            TWO: begin
              if (ret) begin
                state_d  = ONE;
                pop_skid = 1'b1;
              end
            end
            default: state_d = EMPTY;
          endcase
        end
      end

      // in_ready is its own flop, computed from next state, so out_ready
      // never reaches fetch combinationally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          rdy_q   <= 1'b1;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          rdy_q   <= (state_d != TWO);
          if (load_main) begin
            main_q <= in_ent;
          end else if (pop_skid) begin
            main_q <= skid_q;
          end
          if (load_skid) begin
            skid_q <= in_ent;
          end
        end
      end

      assign out_valid = (state_q != EMPTY);
      assign in_ready  = rdy_q;
    end else begin : g_noskid
      logic valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (acc) begin
          valid_q <= 1'b1;
          main_q  <= in_ent;
        end else if (ret) begin
          valid_q <= 1'b0;
        end
      end

      assign out_valid = valid_q;
      assign in_ready  = !valid_q || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_immgen_pipe.sv
// Purpose: scoreboard bench for immgen_pipe; instance a is XLEN=32/SKID=1, instance b is XLEN=64/SKID=0.
// Latency: drivers present inputs on the falling edge; the monitors sample 1 time unit before each rising edge.
// Backpressure: drivers hold in_valid until in_ready; monitors pop the expected queue on every valid&&ready.
module tb_immgen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] ins;
    logic [31:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_ins, a_in_tag, a_out_imm, a_out_ins, a_out_tag;
  logic [2:0]  a_out_fmt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_ins, b_in_tag, b_out_ins, b_out_tag;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;

  exp_t qa[$];
  exp_t qb[$];
  int   nchecks = 0;
  int   nerrors = 0;

  always #5 clk = ~clk;

  immgen_pipe #(.XLEN(32), .TAG_W(32), .SKID(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ins(a_in_ins), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_illegal(a_out_illegal), .out_ins(a_out_ins), .out_tag(a_out_tag)
  );

  immgen_pipe #(.XLEN(64), .TAG_W(32), .SKID(0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ins(b_in_ins), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_illegal(b_out_illegal), .out_ins(b_out_ins), .out_tag(b_out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Call on a falling edge; returns on the falling edge after the accept.
  task automatic send_a(input logic [31:0] ins, input logic [31:0] tag,
                        input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    int n = 0;
    exp_t e;
    a_in_valid = 1'b1;
    a_in_ins   = ins;
    a_in_tag   = tag;
    forever begin
      #1;
      if (a_in_ready) break;
      n++;
      if (n > 100) begin
        chk("a_accept_timeout", 64'(n), 64'd0);
        a_in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e = '{imm, fmt, ill, ins, tag};
    qa.push_back(e);
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] ins, input logic [31:0] tag,
                        input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    int n = 0;
    exp_t e;
    b_in_valid = 1'b1;
    b_in_ins   = ins;
    b_in_tag   = tag;
    forever begin
      #1;
      if (b_in_ready) break;
      n++;
      if (n > 100) begin
        chk("b_accept_timeout", 64'(n), 64'd0);
        b_in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e = '{imm, fmt, ill, ins, tag};
    qb.push_back(e);
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  // Monitors: sample just before the rising edge on which the retire happens.
  always begin : mon_a
    exp_t e;
    @(negedge clk);
    #4;
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_output_tag", 64'(a_out_tag), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = qa.pop_front();
        chk("a_imm", 64'(a_out_imm), 64'(e.imm[31:0]));
        chk("a_fmt", 64'(a_out_fmt), 64'(e.fmt));
        chk("a_illegal", 64'(a_out_illegal), 64'(e.ill));
        chk("a_ins", 64'(a_out_ins), 64'(e.ins));
        chk("a_tag", 64'(a_out_tag), 64'(e.tag));
      end
    end
  end

  always begin : mon_b
    exp_t e;
    @(negedge clk);
    #4;
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_output_tag", 64'(b_out_tag), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = qb.pop_front();
        chk("b_imm", b_out_imm, e.imm);
        chk("b_fmt", 64'(b_out_fmt), 64'(e.fmt));
        chk("b_illegal", 64'(b_out_illegal), 64'(e.ill));
        chk("b_ins", 64'(b_out_ins), 64'(e.ins));
        chk("b_tag", 64'(b_out_tag), 64'(e.tag));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_ins = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_ins = '0; b_in_tag = '0; b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_out_imm", 64'(a_out_imm), 64'd0);
    chk("rst_a_out_fmt", 64'(a_out_fmt), 64'd0);
    chk("rst_a_out_illegal", 64'(a_out_illegal), 64'd0);
    chk("rst_a_out_ins", 64'(a_out_ins), 64'd0);
    chk("rst_a_out_tag", 64'(a_out_tag), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // I-type into an empty pipe: one-cycle latency
    chk("a_empty_before_send", 64'(a_out_valid), 64'd0);
    send_a(32'hFFF00093, 32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    #1;
    chk("a_latency_out_valid", 64'(a_out_valid), 64'd1);
    @(negedge clk);

    // S, B back to back, then illegal encodings, R-type and auipc
    send_a(32'hFE112E23, 32'h101, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    send_a(32'hFE000CE3, 32'h102, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0);
    send_a(32'h00000000, 32'h103, 64'h0, 3'd0, 1'b1);
    send_a(32'h0000007F, 32'h104, 64'h0, 3'd0, 1'b1);
    send_a(32'h002081B3, 32'h105, 64'h0, 3'd0, 1'b0);
    send_a(32'h12345097, 32'h106, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
    repeat (3) @(negedge clk);

    // Backpressure: tags 1,2 fill the pipe, tag 3 waits upstream
    a_out_ready = 1'b0;
    fork
      begin
        send_a(32'h00500093, 32'd1, 64'd5, 3'd1, 1'b0);
        send_a(32'h00500093, 32'd2, 64'd5, 3'd1, 1'b0);
        send_a(32'h00500093, 32'd3, 64'd5, 3'd1, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        #2;
        chk("a_bp_in_ready_full", 64'(a_in_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("a_bp_hold_valid", 64'(a_out_valid), 64'd1);
        chk("a_bp_hold_tag", 64'(a_out_tag), 64'd1);
        a_out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);

    // Flush while full with an entry on offer
    a_out_ready = 1'b0;
    send_a(32'h00700093, 32'd20, 64'd7, 3'd1, 1'b0);
    send_a(32'h00700093, 32'd21, 64'd7, 3'd1, 1'b0);
    a_in_valid = 1'b1; a_in_ins = 32'h00900093; a_in_tag = 32'hBAD0;
    a_flush = 1'b1;
    qa.delete();
    @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1;
    chk("a_flush_full_out_valid", 64'(a_out_valid), 64'd0);
    chk("a_flush_full_in_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);

    // Flush with one entry held and an accept in the same cycle
    send_a(32'h00700093, 32'd22, 64'd7, 3'd1, 1'b0);
    a_in_valid = 1'b1; a_in_ins = 32'h00900093; a_in_tag = 32'hBAD1;
    a_flush = 1'b1;
    qa.delete();
    @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1;
    chk("a_flush_one_out_valid", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    a_out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-stream
    a_out_ready = 1'b0;
    send_a(32'h00700093, 32'd30, 64'd7, 3'd1, 1'b0);
    send_a(32'h00700093, 32'd31, 64'd7, 3'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_arst_out_valid", 64'(a_out_valid), 64'd0);
    chk("a_arst_in_ready", 64'(a_in_ready), 64'd1);
    chk("a_arst_out_tag", 64'(a_out_tag), 64'd0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b1;
    send_a(32'hFFF00093, 32'd32, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    repeat (3) @(negedge clk);

    // Instance b: XLEN=64, single register
    send_b(32'h001000EF, 32'h200, 64'h0000_0000_0000_0800, 3'd5, 1'b0);
    send_b(32'h800002B7, 32'h201, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    send_b(32'hFFF00093, 32'h202, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    send_b(32'hFE000CE3, 32'h203, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0);
    send_b(32'hFE112E23, 32'h204, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    send_b(32'h0000007F, 32'h205, 64'h0, 3'd0, 1'b1);
    send_b(32'h002081B3, 32'h206, 64'h0, 3'd0, 1'b0);
    repeat (3) @(negedge clk);

    b_out_ready = 1'b0;
    fork
      begin
        send_b(32'h00500093, 32'd1, 64'd5, 3'd1, 1'b0);
        send_b(32'h00500093, 32'd2, 64'd5, 3'd1, 1'b0);
      end
      begin
        @(negedge clk);
        #2;
        chk("b_bp_in_ready_full", 64'(b_in_ready), 64'd0);
        repeat (2) @(negedge clk);
        b_out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);

    b_out_ready = 1'b0;
    send_b(32'h00700093, 32'd40, 64'd7, 3'd1, 1'b0);
    b_in_valid = 1'b1; b_in_ins = 32'h00900093; b_in_tag = 32'hBAD2;
    b_flush = 1'b1;
    qb.delete();
    @(negedge clk);
    b_flush = 1'b0; b_in_valid = 1'b0;
    #1;
    chk("b_flush_out_valid", 64'(b_out_valid), 64'd0);
    chk("b_flush_in_ready", 64'(b_in_ready), 64'd1);
    @(negedge clk);
    b_out_ready = 1'b1;

    repeat (10) @(negedge clk);
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
Registered, handshaked immediate generator for the decode stage. It handles all RV32I/RV64I immediate formats (I, S, B, U, J) and sign-extends each immediate to XLEN. It emits a format code and an illegal-opcode flag alongside the immediate. An optional skid register decouples in_ready from out_ready so decode can stall without a combinational ready path back to fetch.

Parameters:
XLEN, 32, output immediate width; legal values are 32 and 64.
TAG_W, 32, width of the sideband tag (typically the PC) carried alongside the instruction.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single pipeline register with combinational in_ready.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; drops all held entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept this cycle
in_ins  in  32  instruction word
in_tag  in  TAG_W  sideband tag
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  0=NONE/R, 1=I, 2=S, 3=B, 4=U, 5=J
out_illegal  out  1  opcode not recognised
out_ins  out  32  registered instruction word
out_tag  out  TAG_W  registered tag

Behaviour:
- Reset clock and polarity: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_ins=0, out_tag=0. in_ready=1 (SKID=1). Internal state is EMPTY.
- Transfers:
  - Accept occurs when in_valid && in_ready.
  - Retire occurs when out_valid && out_ready.
  - Latency is one cycle from accept to out_valid when the block is empty.
- Decode on opcode in_ins[6:0]; the result is computed combinationally and registered on accept.
  - 0010011, 0000011, 1100111, 1110011 -> I: sext(ins[31:20]).
  - 0100011 -> S: sext({ins[31:25],ins[11:7]}).
  - 1100011 -> B: sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}).
  - 0110111, 0010111 -> U: sext({ins[31:12],12'b0}). Sign extension applies from bit 31 when XLEN=64.
  - 1101111 -> J: sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}).
  - 0110011, 0001111 -> fmt NONE, imm 0, not illegal.
  - Any other opcode, or ins[1:0] != 2'b11 -> fmt NONE, imm 0, out_illegal=1. The entry still flows through; it is not dropped.
- SKID=1 state machine (main register + skid register):
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept and retire -> ONE; main register loads the new entry.
    - Accept only -> TWO; the new entry goes to the skid register.
    - Retire only -> EMPTY.
  - TWO: out_valid=1, in_ready=0. Retire -> ONE; skid moves to main.
  - in_ready is a pure register output with no combinational path from out_ready.
- SKID=0: single register.
  - in_ready = !out_valid || out_ready.
  - Accept and retire in the same cycle keeps out_valid high with the new data.
- Ordering: strictly FIFO; no entry is lost or duplicated.
- Output stability: outputs are held stable while out_valid && !out_ready.
- Flush:
  - Next state is EMPTY and out_valid=0.
  - Any accept in the same cycle is discarded.
  - Flush has priority over accept and retire.
  - in_ready=1 in the cycle after a flush.
- Async reset mid-transfer: all state clears immediately; no partial entry survives.
- Data registers need not clear on flush; only valid and state bits must.

Test Plan:
- I-type, XLEN=32, empty pipe: in_ins=0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- S-type and B-type back-to-back with out_ready=1:
  - 0xFE112E23 -> out_imm=0xFFFFFFFC, fmt=2.
  - 0xFE000CE3 -> out_imm=0xFFFFFFF8, fmt=3.
  - One result per cycle, in order.
- J-type and U-type at XLEN=64:
  - 0x001000EF -> out_imm=0x0000000000000800, fmt=5.
  - 0x800002B7 (lui) -> out_imm=0xFFFFFFFF80000000, fmt=4.
- Backpressure, SKID=1: out_ready=0, offer tags 1,2,3 -> tags 1 and 2 accepted; in_ready=0 in the cycle after the second accept; tag 3 held upstream. Raise out_ready -> tags emerge 1,2,3 with no gaps or duplicates.
- Illegal encodings: in_ins=0x00000000 and 0x0000007F -> out_illegal=1, out_imm=0, fmt=0.
- Flush and reset:
  - Pipe in TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry never appears.
  - Deassert rst_n asynchronously mid-stream -> out_valid drops immediately.
